// File: rtl/conf_mul_pkg.sv
// Shared constants and helpers for the configurable integer multiplier family.
// Widths up to MAX_W are supported; callers slice the helpers to their data path.
package conf_mul_pkg;

   localparam int MAX_W = 64;

   localparam logic MODE_ACC = 1'b0;
   localparam logic MODE_APX = 1'b1;

   localparam logic [MAX_W-1:0] SAT_ONES = '1;

   // Keeps the top op_w bits of a dp_w-bit operand and clears the rest.
   function automatic logic [MAX_W-1:0] apx_mask(input int dp_w, input int op_w);
      logic [MAX_W-1:0] m;
      m = '0;
      for (int i = 0; i < MAX_W; i++) begin
         m[i] = (i < dp_w) && (i >= dp_w - op_w);
      end
      return m;
   endfunction

endpackage

// File: rtl/conf_int_mul_pipe_stage.sv
// One pipeline slot: a valid bit plus its payload, loaded on enable.
// The payload only changes when a real beat arrives, so outputs hold while the pipe drains.
module conf_int_mul_pipe_stage import conf_mul_pkg::*; #(
   parameter int PAYLOAD_W = 18
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load,
   input  logic                 vld_in,
   input  logic [PAYLOAD_W-1:0] payload_in,
   output logic                 vld,
   output logic [PAYLOAD_W-1:0] payload
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld     <= 1'b0;
         payload <= '0;
      end else if (load) begin
         vld <= vld_in;
         if (vld_in) begin
            payload <= payload_in;
         end
      end
   end

endmodule

// File: rtl/conf_int_mul_pipe.sv
// Pipelined accurate/approximate unsigned multiplier with valid/ready on both sides.
// Each result carries its own mode tag and overflow flag through the stage chain.
module conf_int_mul_pipe import conf_mul_pkg::*; #(
   parameter int OP_BITWIDTH        = 16,
   parameter int DATA_PATH_BITWIDTH = 16,
   parameter int PIPE_STAGES        = 3,
   parameter int SAT                = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          racc,
   input  logic                          rapx,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [DATA_PATH_BITWIDTH-1:0] a,
   input  logic [DATA_PATH_BITWIDTH-1:0] b,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_PATH_BITWIDTH-1:0] d,
   output logic                          d_apx,
   output logic                          ovf,
   output logic                          apx_mode
);

   localparam int W    = DATA_PATH_BITWIDTH;
   localparam int PW   = W + 2;
   localparam int LAST = PIPE_STAGES - 1;

   localparam logic [MAX_W-1:0] MASK_FULL = apx_mask(W, OP_BITWIDTH);
   localparam logic [W-1:0]     OP_MASK   = MASK_FULL[W-1:0];
   localparam logic [W-1:0]     SAT_VAL   = SAT_ONES[W-1:0];

   function automatic logic [W-1:0] sat_wrap(input logic [2*W-1:0] p, input logic o);
      if ((SAT != 0) && o) begin
         return SAT_VAL;
      end
      return p[W-1:0];
   endfunction

   // racc has priority; the new mode only affects beats accepted after this edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         apx_mode <= MODE_ACC;
      end else if (racc) begin
         apx_mode <= MODE_ACC;
      end else if (rapx) begin
         apx_mode <= MODE_APX;
      end
   end

   // Stage p0: masking, full-width product, overflow and saturation ahead of the first register
   logic [W-1:0]   a_p0, b_p0, d_p0;
   logic [2*W-1:0] prod_p0;
   logic           ovf_p0;
   logic [PW-1:0]  pl_p0;

   always_comb begin
      a_p0    = (apx_mode == MODE_APX) ? (a & OP_MASK) : a;
      b_p0    = (apx_mode == MODE_APX) ? (b & OP_MASK) : b;
      prod_p0 = {{W{1'b0}}, a_p0} * {{W{1'b0}}, b_p0};
      ovf_p0  = |prod_p0[2*W-1:W];
      d_p0    = sat_wrap(prod_p0, ovf_p0);
      pl_p0   = {apx_mode, ovf_p0, d_p0};
   end

   // Stages p1..pN: registered slots with a ready chain running back from the output
   logic [PIPE_STAGES-1:0] stg_vld;
   logic [PIPE_STAGES-1:0] stg_ld;
   logic [PW-1:0]          stg_pl [PIPE_STAGES];

   always_comb begin
      stg_ld       = '0;
      stg_ld[LAST] = !stg_vld[LAST] || out_ready;
      for (int k = PIPE_STAGES - 2; k >= 0; k--) begin
         stg_ld[k] = !stg_vld[k] || stg_ld[k+1];
      end
   end

   for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
      logic          vin;
      logic [PW-1:0] pin;
      if (k == 0) begin : g_first
         assign vin = in_valid;
         assign pin = pl_p0;
      end else begin : g_rest
         assign vin = stg_vld[k-1];
         assign pin = stg_pl[k-1];
      end
      conf_int_mul_pipe_stage #(.PAYLOAD_W(PW)) u_stage (
         .clk        (clk),
         .rst_n      (rst_n),
         .load       (stg_ld[k]),
         .vld_in     (vin),
         .payload_in (pin),
         .vld        (stg_vld[k]),
         .payload    (stg_pl[k])
      );
   end

   assign in_ready            = stg_ld[0];
   assign out_valid           = stg_vld[LAST];
   assign {d_apx, ovf, d}     = stg_pl[LAST];

endmodule

// File: tb/tb_conf_int_mul_pipe.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
// A saturating and a wrapping instance share the same stimulus.
module tb_conf_int_mul_pipe;

   localparam int W  = 16;
   localparam int OP = 12;
   localparam int PS = 3;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         racc = 1'b0, rapx = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
   logic [W-1:0] a = '0, b = '0;

   logic         in_ready, out_valid, d_apx, ovf, apx_mode;
   logic [W-1:0] d;
   logic         in_ready_w, out_valid_w, d_apx_w, ovf_w, apx_mode_w;
   logic [W-1:0] d_w;

   conf_int_mul_pipe #(.OP_BITWIDTH(OP), .DATA_PATH_BITWIDTH(W), .PIPE_STAGES(PS), .SAT(1)) dut (
      .clk(clk), .rst_n(rst_n), .racc(racc), .rapx(rapx), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .d(d), .d_apx(d_apx), .ovf(ovf),
      .apx_mode(apx_mode));

   conf_int_mul_pipe #(.OP_BITWIDTH(OP), .DATA_PATH_BITWIDTH(W), .PIPE_STAGES(PS), .SAT(0)) dut_wrap (
      .clk(clk), .rst_n(rst_n), .racc(racc), .rapx(rapx), .in_valid(in_valid), .in_ready(in_ready_w),
      .a(a), .b(b), .out_valid(out_valid_w), .out_ready(out_ready), .d(d_w), .d_apx(d_apx_w), .ovf(ovf_w),
      .apx_mode(apx_mode_w));

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] ds;
      logic [W-1:0] dw;
      logic         ov;
      logic         apx;
      int           cyc;
   } exp_t;

   exp_t         q[$];
   int           n_checks = 0, n_fail = 0;
   int           cyc = 0, n_out = 0;
   logic         tb_mode = 1'b0;
   logic         chk_lat = 1'b1;
   logic         last_acc = 1'b0;
   logic [W-1:0] last_d = '0, last_d_w = '0;
   logic         last_ovf = 1'b0, last_apx = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, expv, $time);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic mode, input int c);
      exp_t e;
      longint unsigned am, bm, p;
      am = ai;
      bm = bi;
      if (mode) begin
         am = (am >> (W - OP)) << (W - OP);
         bm = (bm >> (W - OP)) << (W - OP);
      end
      p     = am * bm;
      e.ov  = (p > 64'hFFFF);
      e.dw  = W'(p % 65536);
      e.ds  = e.ov ? 16'hFFFF : e.dw;
      e.apx = mode;
      e.cyc = c;
      return e;
   endfunction

   // One clock: sample mid-cycle, update the model at the edge, return just after it.
   task automatic cycle();
      exp_t e;
      logic exp_rdy;
      @(negedge clk);
      cyc++;
      exp_rdy = (q.size() < PS) || out_ready;
      check("apx_mode", apx_mode, tb_mode);
      check("wrap apx_mode", apx_mode_w, tb_mode);
      check("in_ready", in_ready, exp_rdy);
      check("wrap in_ready", in_ready_w, exp_rdy);
      if (out_valid) begin
         if (q.size() == 0) begin
            check("spurious out_valid", out_valid, 1'b0);
         end else begin
            e = q[0];
            check("d", d, e.ds);
            check("ovf", ovf, e.ov);
            check("d_apx", d_apx, e.apx);
            check("wrap out_valid", out_valid_w, 1'b1);
            check("wrap d", d_w, e.dw);
            check("wrap ovf", ovf_w, e.ov);
            check("wrap d_apx", d_apx_w, e.apx);
            if (out_ready) begin
               last_d   = d;
               last_d_w = d_w;
               last_ovf = ovf;
               last_apx = d_apx;
               if (chk_lat) check("latency", cyc - e.cyc, PS);
               void'(q.pop_front());
               n_out++;
            end
         end
      end
      last_acc = in_valid && in_ready;
      if (last_acc) q.push_back(model(a, b, tb_mode, cyc));
      @(posedge clk);
      if (racc) tb_mode = 1'b0;
      else if (rapx) tb_mode = 1'b1;
      #1;
   endtask

   task automatic drain(input int max_cyc);
      for (int i = 0; i < max_cyc && q.size() != 0; i++) cycle();
      if (q.size() != 0) check("drain timeout", q.size(), 0);
   endtask

   task automatic beat(input logic [W-1:0] ai, input logic [W-1:0] bi);
      a = ai;
      b = bi;
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
   endtask

   initial begin
      int idx, outs0;
      repeat (3) @(posedge clk);
      #1;
      check("reset out_valid", out_valid, 1'b0);
      check("reset d", d, 16'h0);
      check("reset d_apx", d_apx, 1'b0);
      check("reset ovf", ovf, 1'b0);
      check("reset apx_mode", apx_mode, 1'b0);
      rst_n = 1'b1;
      cycle();

      beat(16'd300, 16'd200);
      drain(10);
      check("t1 d", last_d, 16'd60000);
      check("t1 ovf", last_ovf, 1'b0);
      check("t1 d_apx", last_apx, 1'b0);

      rapx = 1'b1; cycle(); rapx = 1'b0;
      check("t2 apx_mode", apx_mode, 1'b1);
      beat(16'h00FF, 16'h0013);
      drain(10);
      check("t2 apx d", last_d, 16'h0F00);
      check("t2 apx d_apx", last_apx, 1'b1);
      racc = 1'b1; cycle(); racc = 1'b0;
      beat(16'h00FF, 16'h0013);
      drain(10);
      check("t2 acc d", last_d, 16'h12ED);
      check("t2 acc d_apx", last_apx, 1'b0);

      beat(16'h0100, 16'h0100);
      drain(10);
      check("t3 sat d", last_d, 16'hFFFF);
      check("t3 sat ovf", last_ovf, 1'b1);
      check("t3 wrap d", last_d_w, 16'h0000);

      chk_lat = 1'b0;
      out_ready = 1'b0;
      idx = 1;
      for (int i = 0; i < 6; i++) begin
         in_valid = (idx <= 5);
         a = W'(idx);
         b = 16'd2;
         cycle();
         if (last_acc) idx++;
      end
      check("t4 accepted under backpressure", idx - 1, 3);
      check("t4 in_ready stalled", in_ready, 1'b0);
      out_ready = 1'b1;
      outs0 = n_out;
      for (int i = 0; i < 5; i++) begin
         in_valid = (idx <= 5);
         a = W'(idx);
         b = 16'd2;
         cycle();
         if (last_acc) idx++;
      end
      in_valid = 1'b0;
      check("t4 results after release", n_out - outs0, 5);
      check("t4 last result", last_d, 16'd10);
      drain(10);
      chk_lat = 1'b1;

      rapx = 1'b1; cycle(); rapx = 1'b0;
      racc = 1'b1; rapx = 1'b1;
      beat(16'h00FF, 16'h0013);
      racc = 1'b0; rapx = 1'b0;
      check("t5 apx_mode", apx_mode, 1'b0);
      drain(10);
      check("t5 d", last_d, 16'h0F00);
      check("t5 d_apx", last_apx, 1'b1);

      rapx = 1'b1; cycle(); rapx = 1'b0;
      out_ready = 1'b0;
      beat(16'd5, 16'd6);
      beat(16'd7, 16'd8);
      cycle();
      check("t6 pre-reset out_valid", out_valid, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("t6 reset out_valid", out_valid, 1'b0);
      check("t6 reset apx_mode", apx_mode, 1'b0);
      q.delete();
      tb_mode = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cycle();
         check("t6 no stale output", out_valid, 1'b0);
      end
      beat(16'd7, 16'd9);
      drain(10);
      check("t6 new beat d", last_d, 16'd63);

      chk_lat = 1'b0;
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(3) != 0);
         a = ($urandom_range(1) != 0) ? W'($urandom) : W'($urandom_range(255));
         b = ($urandom_range(1) != 0) ? W'($urandom) : W'($urandom_range(255));
         racc = ($urandom_range(15) == 0);
         rapx = ($urandom_range(15) <= 1);
         cycle();
      end
      in_valid = 1'b0;
      racc = 1'b0;
      rapx = 1'b0;
      out_ready = 1'b1;
      drain(20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
